// File: rtl/i_memory_stage.sv
// Memory-access stage: doubleword data memory with 1-cycle loads, branch resolve, sticky fault flag.
// Optional macro DMEM_BOUNDS_CHECK_EN enables alignment/range/conflict checking and the fault outputs.
`timescale 1ns/1ps
`ifndef WORD
`define WORD 64
`endif

module i_memory_stage #(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [`WORD-1:0]  alu_result,
  input  logic [`WORD-1:0]  read_data2,
  input  logic [`WORD-1:0]  branch_target,
  input  logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic              uncond_branch,
  output logic [`WORD-1:0]  read_data,
  output logic              read_valid,
  output logic              pc_src,
  output logic [`WORD-1:0]  next_branch_pc,
  output logic              mem_fault,
  output logic [`WORD-1:0]  fault_addr
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  logic [ADDR_BITS-1:0] idx_s;
  logic                 do_read_s;
  logic                 do_write_s;
  logic                 fault_s;

  logic [`WORD-1:0]     mem_q [DEPTH];
  logic [`WORD-1:0]     mem_d [DEPTH];
  logic [`WORD-1:0]     read_data_q, read_data_d;
  logic                 read_valid_q, read_valid_d;
  logic                 mem_fault_q, mem_fault_d;
  logic [`WORD-1:0]     fault_addr_q, fault_addr_d;

  assign idx_s          = alu_result[ADDR_BITS+2:3];
  assign pc_src         = uncond_branch | (branch & zero);
  assign next_branch_pc = branch_target;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic aligned_s;
  logic in_range_s;
  logic legal_s;

  assign aligned_s  = (alu_result[2:0] == 3'd0);
  assign in_range_s = (alu_result[`WORD-1:ADDR_BITS+3] == {(`WORD-ADDR_BITS-3){1'b0}});
  assign legal_s    = aligned_s & in_range_s & ~(mem_read & mem_write);
  assign do_read_s  = mem_read & legal_s;
  assign do_write_s = mem_write & legal_s;
  assign fault_s    = (mem_read | mem_write) & ~legal_s;
`else
  // Unchecked build: address wraps on idx bits, and a read/write collision performs only the write.
  assign do_read_s  = mem_read & ~mem_write;
  assign do_write_s = mem_write;
  assign fault_s    = 1'b0;
`endif

  always_comb begin
    mem_d        = mem_q;
    read_data_d  = read_data_q;
    read_valid_d = do_read_s;
    mem_fault_d  = mem_fault_q | fault_s;
    fault_addr_d = fault_addr_q;
    if (do_write_s) begin
      mem_d[idx_s] = read_data2;
    end else begin
      mem_d[idx_s] = mem_q[idx_s];
    end
    if (do_read_s) begin
      read_data_d = mem_q[idx_s];
    end else begin
      read_data_d = read_data_q;
    end
    if (fault_s && !mem_fault_q) begin
      fault_addr_d = alu_result;
    end else begin
      fault_addr_d = fault_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {`WORD{1'b0}};
      end
      read_data_q  <= {`WORD{1'b0}};
      read_valid_q <= 1'b0;
      mem_fault_q  <= 1'b0;
      fault_addr_q <= {`WORD{1'b0}};
    end else begin
      mem_q        <= mem_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      mem_fault_q  <= mem_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign mem_fault  = mem_fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_i_memory_stage.sv
// Directed bench for i_memory_stage: reference memory model plus a queue of expected load data.
`timescale 1ns/1ps

module tb_i_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] alu_result = 64'd0;
  logic [63:0] read_data2 = 64'd0;
  logic [63:0] branch_target = 64'd0;
  logic        zero = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        branch = 1'b0;
  logic        uncond_branch = 1'b0;
  logic [63:0] read_data;
  logic        read_valid;
  logic        pc_src;
  logic [63:0] next_branch_pc;
  logic        mem_fault;
  logic [63:0] fault_addr;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] model [64];
  logic [63:0] sb [$];
  logic [63:0] last_rd = 64'd0;
  logic        exp_fault = 1'b0;
  logic [63:0] exp_faddr = 64'd0;

  i_memory_stage #(.DEPTH(64)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .read_data2(read_data2),
    .branch_target(branch_target), .zero(zero), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .uncond_branch(uncond_branch), .read_data(read_data),
    .read_valid(read_valid), .pc_src(pc_src), .next_branch_pc(next_branch_pc),
    .mem_fault(mem_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 64'd0;
    sb.delete();
    last_rd   = 64'd0;
    exp_fault = 1'b0;
    exp_faddr = 64'd0;
  endtask

  // One clock of memory traffic: drive at negedge, predict, check 1ns after the next posedge.
  task automatic step(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
    logic       lrd;
    logic       lwr;
    logic [5:0] idx;
    logic [63:0] exp;
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    alu_result = addr;
    read_data2 = data;
    idx = addr[8:3];
`ifdef DMEM_BOUNDS_CHECK_EN
    begin
      logic ok;
      ok  = (addr[2:0] == 3'd0) && (addr < 64'd512) && !(rd && wr);
      lrd = rd && ok;
      lwr = wr && ok;
      if ((rd || wr) && !ok && !exp_fault) begin
        exp_fault = 1'b1;
        exp_faddr = addr;
      end
    end
`else
    lrd = rd && !wr;
    lwr = wr;
`endif
    if (lrd) sb.push_back(model[idx]);
    if (lwr) model[idx] = data;
    @(posedge clk);
    #1;
    check("read_valid", {63'd0, read_valid}, {63'd0, lrd});
    if (lrd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty observed=%0d expected=%0d", 0, 1);
      end else begin
        exp = sb.pop_front();
        check("read_data", read_data, exp);
        last_rd = exp;
      end
    end else begin
      check("read_data_hold", read_data, last_rd);
    end
    check("mem_fault", {63'd0, mem_fault}, {63'd0, exp_fault});
    check("fault_addr", fault_addr, exp_faddr);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 64'd0);
    check("rst_read_valid", {63'd0, read_valid}, 64'd0);
    check("rst_mem_fault", {63'd0, mem_fault}, 64'd0);
    check("rst_fault_addr", fault_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    step(1'b1, 1'b0, 64'h10, 64'd0);
    step(1'b0, 1'b1, 64'h28, 64'h00000000DEADBEEF);
    step(1'b1, 1'b0, 64'h28, 64'd0);
    step(1'b1, 1'b0, 64'h20, 64'd0);
    step(1'b1, 1'b0, 64'h30, 64'd0);
    step(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFF3, 64'h1234);
    step(1'b0, 1'b1, 64'h1F8, 64'hA5A5A5A55A5A5A5A);
    step(1'b1, 1'b0, 64'h1F8, 64'd0);

    @(negedge clk);
    branch_target = 64'h0000_0000_0040_1230;
    branch = 1'b1; zero = 1'b1; uncond_branch = 1'b0;
    #1;
    check("pc_src_cbz_taken", {63'd0, pc_src}, 64'd1);
    check("next_branch_pc", next_branch_pc, 64'h0000_0000_0040_1230);
    zero = 1'b0;
    #1;
    check("pc_src_cbz_not", {63'd0, pc_src}, 64'd0);
    branch = 1'b0; uncond_branch = 1'b1;
    branch_target = 64'hFFFF_0000_1111_2222;
    #1;
    check("pc_src_uncond", {63'd0, pc_src}, 64'd1);
    check("next_branch_pc2", next_branch_pc, 64'hFFFF_0000_1111_2222);
    uncond_branch = 1'b0;

`ifdef DMEM_BOUNDS_CHECK_EN
    step(1'b1, 1'b0, 64'h0C, 64'd0);
    step(1'b0, 1'b1, 64'h200, 64'h77);
    step(1'b1, 1'b1, 64'h28, 64'h99);
    step(1'b1, 1'b0, 64'h0, 64'd0);
    step(1'b1, 1'b0, 64'h28, 64'd0);
`else
    step(1'b0, 1'b1, 64'h200, 64'h55);
    step(1'b1, 1'b0, 64'h0, 64'd0);
    step(1'b1, 1'b1, 64'h30, 64'h99);
    step(1'b1, 1'b0, 64'h30, 64'd0);
    step(1'b1, 1'b0, 64'h2D, 64'd0);
`endif

    step(1'b0, 1'b1, 64'h8, 64'h1111);
    step(1'b0, 1'b1, 64'h18, 64'h2222);
    step(1'b1, 1'b0, 64'h8, 64'd0);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    alu_result = 64'h18;
    read_data2 = 64'hBAD;
    reset = 1'b1;
    #1;
    check("rst_async_valid", {63'd0, read_valid}, 64'd0);
    check("rst_async_data", read_data, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    reset = 1'b0;
    step(1'b1, 1'b0, 64'h8, 64'd0);
    step(1'b1, 1'b0, 64'h18, 64'd0);
    step(1'b0, 1'b0, 64'd0, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i_memory_stage.md
Name: i_memory_stage

Overview:
Memory-access stage directly downstream of the execute stage. Consumes the ALU result (used as byte address), the store data (read_data2), zero and branch_target, and holds a doubleword-addressed data memory. Loads return data one cycle later. The stage also resolves the branch decision (pc_src) for the fetch stage and flags illegal accesses.

Parameters:
DEPTH, 64, number of `WORD-bit (64-bit) doublewords in the data memory; power of two, min 8
ADDR_BITS, $clog2(DEPTH), doubleword index width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
alu_result  input  `WORD  byte address from execute
read_data2  input  `WORD  store data from execute
branch_target  input  `WORD  branch target from execute
zero  input  1  ALU zero flag from execute
mem_read  input  1  load request, sampled at posedge
mem_write  input  1  store request, sampled at posedge
branch  input  1  conditional branch (CBZ)
uncond_branch  input  1  unconditional branch (B)
read_data  output  `WORD  registered load data
read_valid  output  1  one-cycle pulse: read_data updated this cycle
pc_src  output  1  1 = fetch takes branch_target
next_branch_pc  output  `WORD  branch_target passed through
mem_fault  output  1  sticky illegal-access flag
fault_addr  output  `WORD  address of the first faulting access

Behaviour:
- Reset (async, active-high):
  - read_data=0, read_valid=0, mem_fault=0, fault_addr=0.
  - All DEPTH memory entries cleared to 0.
  - Reset mid-access aborts it; no write lands while reset is high.
- Branch logic is combinational, with no clock dependency:
  - pc_src = uncond_branch | (branch & zero).
  - next_branch_pc = branch_target.
- Index: idx = alu_result[ADDR_BITS+2:3]. Byte address bits [2:0] are not used for data selection.
- Legal access, with the check compiled in: alu_result[2:0]==0, alu_result < DEPTH*8, and not (mem_read & mem_write).
- Store, at posedge when mem_write and legal: mem[idx] <= read_data2. Takes effect for any read in a later cycle.
- Load, at posedge when mem_read and legal:
  - read_data <= mem[idx]; read_valid <= 1 in the following cycle. Latency is 1 cycle.
  - Back-to-back loads are supported at 1 per cycle; read_valid stays high across consecutive legal loads.
- No load that cycle: read_valid <= 0; read_data holds its last value.
- Load from the address stored in the previous cycle returns the new data.
- Illegal access (a request with the check failing):
  - No memory change; read_valid <= 0.
  - mem_fault <= 1, and stays 1 until reset.
  - fault_addr captured only on the first fault (while mem_fault==0); later faults do not overwrite it.
- mem_read & mem_write together is always illegal and is treated as a fault.
- mem_read=mem_write=0: no memory activity and no fault checking, whatever alu_result holds.

Optional Feature:
DMEM_BOUNDS_CHECK_EN
- Defined: legality checks as above; mem_fault and fault_addr are live.
- Undefined:
  - Misalignment is ignored (bits [2:0] dropped).
  - The address wraps modulo DEPTH*8 (only idx bits used).
  - mem_read & mem_write together performs the write only, with no read_valid.
  - mem_fault and fault_addr are tied to 0.

Test Plan:
- Reset, then load addr 0x10 → read_valid=1 one cycle later, read_data=0; mem_fault=0.
- Store 0x00000000DEADBEEF to addr 0x28, load 0x28 next cycle → read_data=0xDEADBEEF on the cycle after the load; loads of 0x20 and 0x30 return 0.
- branch=1, zero=1 → pc_src=1 and next_branch_pc=branch_target, same cycle. branch=1, zero=0, uncond_branch=0 → pc_src=0. uncond_branch=1, zero=0 → pc_src=1.
- (EN defined) Load addr 0x0C (misaligned), then store to DEPTH*8 (0x200) → mem_fault=1, fault_addr=0x0C (not 0x200), read_valid stays 0, memory unchanged.
- (EN undefined) Store 0x55 to 0x200, load addr 0x0 → read_data=0x55 (wrap); mem_fault=0.
- Assert reset while a load is in flight, after stores to 0x8 and 0x18 → read_valid=0 and read_data=0 immediately. After reset deasserts, loads of 0x8 and 0x18 return 0.
